// File: rtl/logo_bounce_controller.sv
// Logo position controller: moves a LOGO_SIZE square once per frame, bouncing
// off the screen edges, and maps each pixel to an in-logo flag and ROM coordinates.
module logo_bounce_controller #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int LOGO_SIZE = 128,
    parameter int SPEED     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    output logic       in_logo,
    output logic [6:0] rom_x,
    output logic [6:0] rom_y,
    output logic [2:0] color_index,
    output logic       bounce,
    output logic       corner
);

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    typedef struct packed {
        logic [9:0] pos;
        dir_t       dir;
        logic       hit;
    } axis_t;

    localparam logic [9:0]  MAX_X  = 10'(H_ACTIVE - LOGO_SIZE);
    localparam logic [9:0]  MAX_Y  = 10'(V_ACTIVE - LOGO_SIZE);
    localparam logic [10:0] SIZE_W = 11'(LOGO_SIZE);
    localparam logic [10:0] STEP_W = 11'(SPEED);
    localparam logic [9:0]  STEP   = 10'(SPEED);
    localparam logic [9:0]  V_TICK = 10'(V_ACTIVE);

    logic [9:0] pos_x;
    logic [9:0] pos_y;
    dir_t       dir_x;
    dir_t       dir_y;
    logic [2:0] color;

    logic       tick;
    axis_t      nx_x;
    axis_t      nx_y;
    logic [2:0] color_nx;

    // One axis step; increasing compare is done in 11 bits so pos + SPEED cannot wrap,
    // and both directions clamp to the limit so pos never leaves 0..max.
    function automatic axis_t step_axis(input logic [9:0] pos, input dir_t dir,
                                        input logic [9:0] max_pos);
        axis_t r;
        r.pos = pos;
        r.dir = dir;
        r.hit = 1'b0;
        if (dir == DIR_INC) begin
            if (({1'b0, pos} + STEP_W) >= {1'b0, max_pos}) begin
                r.pos = max_pos;
                r.dir = DIR_DEC;
                r.hit = 1'b1;
            end else begin
                r.pos = pos + STEP;
            end
        end else begin
            if (pos <= STEP) begin
                r.pos = '0;
                r.dir = DIR_INC;
                r.hit = 1'b1;
            end else begin
                r.pos = pos - STEP;
            end
        end
        return r;
    endfunction

    // Frame tick and candidate next motion state for both axes.
    always_comb begin
        tick     = (hpos == '0) && (vpos == V_TICK);
        nx_x     = step_axis(pos_x, dir_x, MAX_X);
        nx_y     = step_axis(pos_y, dir_y, MAX_Y);
        color_nx = (color == 3'd7) ? 3'd1 : color + 3'd1;
    end

    // Motion state, colour and one-cycle edge pulses; updated only on an enabled tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x  <= '0;
            pos_y  <= '0;
            dir_x  <= DIR_INC;
            dir_y  <= DIR_INC;
            color  <= 3'd1;
            bounce <= 1'b0;
            corner <= 1'b0;
        end else begin
            bounce <= 1'b0;
            corner <= 1'b0;
            if (tick && enable) begin
                pos_x  <= nx_x.pos;
                dir_x  <= nx_x.dir;
                pos_y  <= nx_y.pos;
                dir_y  <= nx_y.dir;
                bounce <= nx_x.hit | nx_y.hit;
                corner <= nx_x.hit & nx_y.hit;
                if (nx_x.hit | nx_y.hit) begin
                    color <= color_nx;
                end
            end
        end
    end

    // Zero-latency pixel lookup; bounds compared in 11 bits to avoid overflow at pos + size.
    always_comb begin
        in_logo = display_on
                  && ({1'b0, hpos} >= {1'b0, pos_x})
                  && ({1'b0, hpos} <  ({1'b0, pos_x} + SIZE_W))
                  && ({1'b0, vpos} >= {1'b0, pos_y})
                  && ({1'b0, vpos} <  ({1'b0, pos_y} + SIZE_W));
        rom_x       = hpos[6:0] - pos_x[6:0];
        rom_y       = vpos[6:0] - pos_y[6:0];
        color_index = color;
    end

endmodule

// File: tb/tb_logo_bounce_controller.sv
// Directed bench for logo_bounce_controller across four parameterisations.
module tb_logo_bounce_controller;

    logic       clk = 1'b0;
    logic       reset[4];
    logic       enable[4];
    logic [9:0] hpos[4];
    logic [9:0] vpos[4];
    logic       display_on[4];
    logic       in_logo[4];
    logic [6:0] rom_x[4];
    logic [6:0] rom_y[4];
    logic [2:0] color_index[4];
    logic       bounce[4];
    logic       corner[4];

    int n_checks = 0;
    int n_errors = 0;
    logic tb_bounce;
    logic tb_corner;

    always #5 clk = ~clk;

    // 0: defaults; 1: 256x256 screen; 2: SPEED=3; 3: H_ACTIVE=143 (MAX_X=15).
    logo_bounce_controller dut0 (
        .clk(clk), .reset(reset[0]), .enable(enable[0]), .hpos(hpos[0]), .vpos(vpos[0]),
        .display_on(display_on[0]), .in_logo(in_logo[0]), .rom_x(rom_x[0]), .rom_y(rom_y[0]),
        .color_index(color_index[0]), .bounce(bounce[0]), .corner(corner[0]));

    logo_bounce_controller #(.H_ACTIVE(256), .V_ACTIVE(256), .LOGO_SIZE(128), .SPEED(1)) dut1 (
        .clk(clk), .reset(reset[1]), .enable(enable[1]), .hpos(hpos[1]), .vpos(vpos[1]),
        .display_on(display_on[1]), .in_logo(in_logo[1]), .rom_x(rom_x[1]), .rom_y(rom_y[1]),
        .color_index(color_index[1]), .bounce(bounce[1]), .corner(corner[1]));

    logo_bounce_controller #(.SPEED(3)) dut2 (
        .clk(clk), .reset(reset[2]), .enable(enable[2]), .hpos(hpos[2]), .vpos(vpos[2]),
        .display_on(display_on[2]), .in_logo(in_logo[2]), .rom_x(rom_x[2]), .rom_y(rom_y[2]),
        .color_index(color_index[2]), .bounce(bounce[2]), .corner(corner[2]));

    logo_bounce_controller #(.H_ACTIVE(143)) dut3 (
        .clk(clk), .reset(reset[3]), .enable(enable[3]), .hpos(hpos[3]), .vpos(vpos[3]),
        .display_on(display_on[3]), .in_logo(in_logo[3]), .rom_x(rom_x[3]), .rom_y(rom_y[3]),
        .color_index(color_index[3]), .bounce(bounce[3]), .corner(corner[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] v_tick_of(input int idx);
        return (idx == 1) ? 10'd256 : 10'd480;
    endfunction

    // Present one frame tick to instance idx and capture the pulses it produces.
    task automatic do_tick(input int idx);
        hpos[idx] = 10'd0;
        vpos[idx] = v_tick_of(idx);
        @(posedge clk);
        #1;
        hpos[idx] = 10'd5;
        vpos[idx] = 10'd0;
        tb_bounce = bounce[idx];
        tb_corner = corner[idx];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic eb, ec;
        for (int i = 0; i < 4; i++) begin
            reset[i] = 1'b1; enable[i] = 1'b1; hpos[i] = 10'd5; vpos[i] = 10'd0; display_on[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) reset[i] = 1'b0;

        check_eq("rst_pos_x", 32'(dut0.pos_x), 0);
        check_eq("rst_pos_y", 32'(dut0.pos_y), 0);
        check_eq("rst_color", 32'(color_index[0]), 1);
        check_eq("rst_bounce", 32'(bounce[0]), 0);
        check_eq("rst_corner", 32'(corner[0]), 0);

        // Default instance: y bounces every 352 ticks, x every 512.
        nb = 0;
        for (int k = 1; k <= 2100; k++) begin
            do_tick(0);
            eb = ((k % 352) == 0) || ((k % 512) == 0);
            ec = ((k % 352) == 0) && ((k % 512) == 0);
            if (eb) nb++;
            check_eq("d_bounce", 32'(tb_bounce), 32'(eb));
            check_eq("d_corner", 32'(tb_corner), 32'(ec));
            check_eq("d_color", 32'(color_index[0]), 32'((nb % 7) + 1));
            if (k == 1) begin
                check_eq("t1_pos_x", 32'(dut0.pos_x), 1);
                check_eq("t1_pos_y", 32'(dut0.pos_y), 1);
            end
            if (k == 352) check_eq("t352_pos_y", 32'(dut0.pos_y), 352);
            if (k == 512) begin
                check_eq("t512_pos_x", 32'(dut0.pos_x), 512);
                check_eq("t512_dir_x", 32'(dut0.dir_x), 1);
            end
            if (k == 513) check_eq("t513_pos_x", 32'(dut0.pos_x), 511);
            if (k == 704) check_eq("t704_pos_y", 32'(dut0.pos_y), 0);
        end

        // 256x256 screen: both axes hit 128 on the same tick.
        for (int k = 1; k <= 128; k++) begin
            do_tick(1);
            check_eq("s_bounce", 32'(tb_bounce), (k == 128) ? 1 : 0);
            check_eq("s_corner", 32'(tb_corner), (k == 128) ? 1 : 0);
        end
        check_eq("s_pos_x", 32'(dut1.pos_x), 128);
        check_eq("s_pos_y", 32'(dut1.pos_y), 128);
        check_eq("s_color", 32'(color_index[1]), 2);

        // SPEED=3: x reaches 510 after 170 ticks, y bounced at tick 118.
        for (int k = 1; k <= 170; k++) do_tick(2);
        check_eq("f_pos_x_510", 32'(dut2.pos_x), 510);
        check_eq("f_color_y", 32'(color_index[2]), 2);
        do_tick(2);
        check_eq("f_pos_x_clamp", 32'(dut2.pos_x), 512);
        check_eq("f_dir_x", 32'(dut2.dir_x), 1);
        check_eq("f_bounce", 32'(tb_bounce), 1);
        check_eq("f_pos_y", 32'(dut2.pos_y), 193);
        check_eq("f_color", 32'(color_index[2]), 3);
        enable[2] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            do_tick(2);
            check_eq("frz_bounce", 32'(tb_bounce), 0);
        end
        check_eq("frz_pos_x", 32'(dut2.pos_x), 512);
        check_eq("frz_pos_y", 32'(dut2.pos_y), 193);
        check_eq("frz_color", 32'(color_index[2]), 3);
        enable[2] = 1'b1;
        hpos[2] = 10'd300; vpos[2] = 10'd100; reset[2] = 1'b1;
        @(posedge clk);
        #1;
        reset[2] = 1'b0;
        check_eq("mrst_pos_x", 32'(dut2.pos_x), 0);
        check_eq("mrst_pos_y", 32'(dut2.pos_y), 0);
        check_eq("mrst_color", 32'(color_index[2]), 1);
        // Reset coinciding with a tick discards the update.
        hpos[2] = 10'd0; vpos[2] = 10'd480; reset[2] = 1'b1;
        @(posedge clk);
        #1;
        reset[2] = 1'b0; hpos[2] = 10'd5; vpos[2] = 10'd0;
        check_eq("trst_pos_x", 32'(dut2.pos_x), 0);
        check_eq("trst_bounce", 32'(bounce[2]), 0);

        // MAX_X=15: after 20 ticks pos=(10,20).
        for (int k = 1; k <= 20; k++) do_tick(3);
        check_eq("l_pos_x", 32'(dut3.pos_x), 10);
        check_eq("l_pos_y", 32'(dut3.pos_y), 20);
        check_eq("l_color", 32'(color_index[3]), 2);
        hpos[3] = 10'd10; vpos[3] = 10'd20; display_on[3] = 1'b1;
        #1;
        check_eq("l_in_origin", 32'(in_logo[3]), 1);
        check_eq("l_romx_origin", 32'(rom_x[3]), 0);
        check_eq("l_romy_origin", 32'(rom_y[3]), 0);
        hpos[3] = 10'd137;
        #1;
        check_eq("l_in_right", 32'(in_logo[3]), 1);
        check_eq("l_romx_right", 32'(rom_x[3]), 127);
        hpos[3] = 10'd138;
        #1;
        check_eq("l_out_right", 32'(in_logo[3]), 0);
        check_eq("l_romx_out", 32'(rom_x[3]), 0);
        hpos[3] = 10'd9;
        #1;
        check_eq("l_out_left", 32'(in_logo[3]), 0);
        check_eq("l_romx_left", 32'(rom_x[3]), 127);
        hpos[3] = 10'd50; vpos[3] = 10'd147;
        #1;
        check_eq("l_in_bottom", 32'(in_logo[3]), 1);
        check_eq("l_romy_bottom", 32'(rom_y[3]), 127);
        check_eq("l_romx_mid", 32'(rom_x[3]), 40);
        vpos[3] = 10'd148;
        #1;
        check_eq("l_out_bottom", 32'(in_logo[3]), 0);
        vpos[3] = 10'd19;
        #1;
        check_eq("l_out_top", 32'(in_logo[3]), 0);
        vpos[3] = 10'd20; hpos[3] = 10'd10; display_on[3] = 1'b0;
        #1;
        check_eq("l_out_blank", 32'(in_logo[3]), 0);
        display_on[3] = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
